fp8_sub_arbiter: RTL and testbench
==================================

FP8_SUB_ARBITER -- requirements
Module: fp8_sub_arbiter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: width of the accepted-operation counter.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst as in the rest of the codebase.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 offers an operation.
REQ-006 req0_a, req0_b  input  8 each  requester 0 FP8 operands (minuend, subtrahend).
REQ-007 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-008 req1_valid, req1_a, req1_b, req1_ready: same directions, widths and meaning as the requester 0 ports, for requester 1.
REQ-009 out_valid  output  1  result register holds a valid result.
REQ-010 out_y  output  8  FP8 result a-b.
REQ-011 out_id  output  1  index of the requester that owns out_y.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 op_count  output  CNT_W  running count of accepted operations.

Function
REQ-014 FP8 format SHALL be: [7] sign, [6:3] exponent with bias 7, [2:0] mantissa; exponent 0 is subnormal (emin=-6); exponent 15 is NaN; no Inf.
REQ-015 Subtraction rules SHALL be:
- any NaN operand -> 0x7F;
- both operands zero -> 0x00;
- a zero -> b with bit 7 inverted;
- b zero -> a unchanged;
- exact zero difference -> 0x00;
- rounding is round-to-nearest-even;
- magnitude overflow (e>7) saturates to {sign,4'hE,3'h7};
- tiny results become subnormal.
REQ-016 can_accept SHALL equal !out_valid || out_ready.
REQ-017 When can_accept is high and exactly one valid is high, that requester SHALL be granted.
REQ-018 When both valids are high, grant SHALL follow a round-robin priority pointer.
REQ-019 The priority pointer SHALL move to the other requester after every grant and SHALL be unchanged in cycles with no grant.
REQ-020 reqN_ready SHALL be combinational, high only when can_accept is high and requester N is granted; at most one ready is high per cycle.
REQ-021 On a clk edge with reqN_valid && reqN_ready, the result register SHALL load out_y = reqN_a - reqN_b and out_id = N, and SHALL set out_valid (latency 1 cycle).
REQ-022 On out_valid && out_ready with no new accept, out_valid SHALL clear on the edge; out_y and out_id keep their last value.
REQ-023 A handoff and a new accept in the same cycle SHALL load the new result, keeping out_valid high; throughput is 1 operation per cycle.
REQ-024 While out_valid && !out_ready, out_y and out_id SHALL be held stable and both readies SHALL be low.
REQ-025 op_count SHALL increment by 1 per accepted operation, wrapping modulo 2^CNT_W.
REQ-026 Requesters hold operands stable while valid && !ready; the block does not check this.

Reset
REQ-027 rst asserted SHALL immediately force out_valid=0, out_y=0x00, out_id=0, op_count=0, and pointer priority = requester 0, independent of clk.
REQ-028 A result pending at reset SHALL be discarded.
REQ-029 Readies SHALL be low while rst is high; operation resumes on the first edge after rst deasserts.

Verification
REQ-030 Reset; req0 a=0x40, b=0x38, out_ready=1 -> next cycle out_valid=1, out_y=0x38, out_id=0, op_count=1.
REQ-031 After reset, both valid every cycle (req0 0x40-0x38, req1 0x38-0x40), out_ready=1 -> grants 0,1,0,1; outputs 0x38/id0, 0xB8/id1 alternating, one per cycle.
REQ-032 out_valid=1, out_ready=0 for 3 cycles with both valid -> readies 0, out_y/out_id constant; raise out_ready -> a new operation is accepted in that same cycle.
REQ-033 Operand checks -> required results:
- a=0x78, b=0x38 -> 0x7F;
- a=0x77, b=0xF7 -> 0x77 (saturation);
- a=0x00, b=0x38 -> 0xB8;
- a=0x01, b=0x01 -> 0x00.
REQ-034 Assert rst between edges while out_valid=1 -> out_valid and op_count read 0 before the next edge; the next accept goes to req0 when both are valid.
REQ-035 CNT_W=2, 4 accepts -> op_count sequence 1,2,3,0.

Source files
------------

// File: rtl/fp8_sub_arbiter_if.sv
// Handshake bundle between two FP8 requesters, the subtract/arbiter block and its consumer.
// The master side drives operands and out_ready; the slave side is the arbiter.
interface fp8_sub_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic [7:0]       req0_a;
    logic [7:0]       req0_b;
    logic             req0_ready;
    logic             req1_valid;
    logic [7:0]       req1_a;
    logic [7:0]       req1_b;
    logic             req1_ready;
    logic             out_valid;
    logic [7:0]       out_y;
    logic             out_id;
    logic             out_ready;
    logic [CNT_W-1:0] op_count;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, out_ready,
        input  req0_ready, req1_ready, out_valid, out_y, out_id, op_count
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, out_ready,
        output req0_ready, req1_ready, out_valid, out_y, out_id, op_count
    );
endinterface

// File: rtl/fp8_sub_arbiter.sv
// Two-requester round-robin arbiter feeding a single-cycle FP8 subtractor (a-b)
// with a one-entry result register and an accepted-operation counter.
module fp8_sub_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    fp8_sub_arbiter_if.slave   bus
);

    // Magnitude in units of 2^-9 (the subnormal LSB); every finite FP8 value is an exact integer here.
    function automatic logic [17:0] fp8_mag(input logic [7:0] x);
        logic [17:0] sig;
        logic [3:0]  sh;
        sig = {14'd0, (x[6:3] != 4'd0), x[2:0]};
        sh  = (x[6:3] == 4'd0) ? 4'd0 : (x[6:3] - 4'd1);
        return sig << sh;
    endfunction

    function automatic logic [7:0] fp8_sub(input logic [7:0] a, input logic [7:0] b);
        logic [17:0] ma, mb, mag, mant, rem, half;
        logic        sign, up;
        logic [4:0]  p, sh, e;
        logic [7:0]  r;
        ma   = fp8_mag(a);
        mb   = fp8_mag(b);
        mag  = 18'd0;
        mant = 18'd0;
        rem  = 18'd0;
        half = 18'd0;
        sign = 1'b0;
        up   = 1'b0;
        p    = 5'd0;
        sh   = 5'd0;
        e    = 5'd0;
        r    = 8'h00;
        if ((a[6:3] == 4'hF) || (b[6:3] == 4'hF)) begin
            r = 8'h7F;
        end else if ((ma == 18'd0) && (mb == 18'd0)) begin
            r = 8'h00;
        end else if (ma == 18'd0) begin
            r = {~b[7], b[6:0]};
        end else if (mb == 18'd0) begin
            r = a;
        end else begin
            // Differing signs add magnitudes; the exact difference is then rounded once.
            if (a[7] != b[7]) begin
                mag  = ma + mb;
                sign = a[7];
            end else if (ma >= mb) begin
                mag  = ma - mb;
                sign = a[7];
            end else begin
                mag  = mb - ma;
                sign = ~a[7];
            end
            if (mag == 18'd0) begin
                r = 8'h00;
            end else if (mag < 18'd8) begin
                r = {sign, 4'h0, mag[2:0]};
            end else begin
                for (int i = 0; i < 18; i++) begin
                    if (mag[i]) begin
                        p = 5'(i);
                    end else begin
                        p = p;
                    end
                end
                sh   = p - 5'd3;
                mant = mag >> sh;
                rem  = mag & ((18'd1 << sh) - 18'd1);
                half = (18'd1 << sh) >> 1;
                up   = (sh != 5'd0) && ((rem > half) || ((rem == half) && mant[0]));
                mant = mant + {17'd0, up};
                e    = p - 5'd2;
                if (mant == 18'd16) begin
                    mant = 18'd8;
                    e    = e + 5'd1;
                end else begin
                    mant = mant;
                end
                if (e > 5'd14) begin
                    r = {sign, 4'hE, 3'h7};
                end else begin
                    r = {sign, e[3:0], mant[2:0]};
                end
            end
        end
        return r;
    endfunction

    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_y_q, out_y_d;
    logic             out_id_q, out_id_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             can_accept_s, grant_s, ready0_s, ready1_s, accept_s;

    // Round-robin grant and combinational readies; readies are forced low during reset.
    always_comb begin
        can_accept_s = !out_valid_q || bus.out_ready;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_s = ptr_q;
        end else if (bus.req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        ready0_s = !rst && can_accept_s && bus.req0_valid && (grant_s == 1'b0);
        ready1_s = !rst && can_accept_s && bus.req1_valid && (grant_s == 1'b1);
        accept_s = ready0_s || ready1_s;
    end

    // Next state of the result register, priority pointer and counter.
    always_comb begin
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_id_d    = out_id_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_id_d    = grant_s;
            out_y_d     = grant_s ? fp8_sub(bus.req1_a, bus.req1_b)
                                  : fp8_sub(bus.req0_a, bus.req0_b);
            ptr_d       = ~grant_s;
            cnt_d       = cnt_q + CNT_W'(1);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with asynchronous reset that discards any pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_y_q     <= 8'h00;
            out_id_q    <= 1'b0;
            ptr_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_id_q    <= out_id_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.req0_ready = ready0_s;
    assign bus.req1_ready = ready1_s;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_y      = out_y_q;
    assign bus.out_id     = out_id_q;
    assign bus.op_count   = cnt_q;

endmodule

// File: tb/tb_fp8_sub_arbiter.sv
// Self-checking bench: directed sequences, an operand vector table, and a randomized
// run against a real-valued FP8 reference model with a nearest-code search.
module tb_fp8_sub_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fp8_sub_arbiter_if #(.CNT_W(16)) bus ();
    fp8_sub_arbiter_if #(.CNT_W(2))  bus2 ();

    fp8_sub_arbiter #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
    fp8_sub_arbiter #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                         input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                         input logic ordy);
        bus.req0_valid = v0;
        bus.req0_a     = a0;
        bus.req0_b     = b0;
        bus.req1_valid = v1;
        bus.req1_a     = a1;
        bus.req1_b     = b1;
        bus.out_ready  = ordy;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    function automatic real fp8_val(input logic [7:0] x);
        real v;
        int  e;
        e = int'(x[6:3]);
        if (e == 0) begin
            v = real'(x[2:0]) / 8.0 / 64.0;
        end else begin
            v = (8.0 + real'(x[2:0])) / 8.0;
            for (int i = 7; i < e; i++) v = v * 2.0;
            for (int i = e; i < 7; i++) v = v / 2.0;
        end
        return x[7] ? -v : v;
    endfunction

    function automatic logic [7:0] ref_sub(input logic [7:0] a, input logic [7:0] b);
        real  va, vb, d, mag, cv, dd, bestd;
        int   best;
        logic [7:0] bcode;
        if (a[6:3] == 4'hF || b[6:3] == 4'hF) return 8'h7F;
        va = fp8_val(a);
        vb = fp8_val(b);
        if (va == 0.0 && vb == 0.0) return 8'h00;
        if (va == 0.0) return b ^ 8'h80;
        if (vb == 0.0) return a;
        d = va - vb;
        if (d == 0.0) return 8'h00;
        mag   = (d < 0.0) ? -d : d;
        best  = 0;
        bestd = 1.0e9;
        for (int c = 0; c <= 8'h77; c++) begin
            cv = fp8_val(8'(c));
            dd = (cv > mag) ? (cv - mag) : (mag - cv);
            if (dd < bestd || (dd == bestd && c[0] == 1'b0)) begin
                best  = c;
                bestd = dd;
            end
        end
        bcode = 8'(best);
        return {(d < 0.0), bcode[6:0]};
    endfunction

    logic        m_valid, m_id, m_ptr, hold0, hold1, v0, v1, ordy, win, can, e0, e1;
    logic [7:0]  m_y, a0, b0, a1, b1;
    logic [15:0] m_cnt;

    initial begin
        vecs[0]  = '{8'h78, 8'h38, 8'h7F};
        vecs[1]  = '{8'h77, 8'hF7, 8'h77};
        vecs[2]  = '{8'h00, 8'h38, 8'hB8};
        vecs[3]  = '{8'h01, 8'h01, 8'h00};
        vecs[4]  = '{8'h40, 8'h38, 8'h38};
        vecs[5]  = '{8'h38, 8'h40, 8'hB8};
        vecs[6]  = '{8'h3C, 8'h38, 8'h30};
        vecs[7]  = '{8'h08, 8'h01, 8'h07};
        vecs[8]  = '{8'h39, 8'h00, 8'h39};
        vecs[9]  = '{8'h80, 8'h00, 8'h00};
        vecs[10] = '{8'h00, 8'h7F, 8'h7F};
        vecs[11] = '{8'h50, 8'h01, 8'h50};
        vecs[12] = '{8'h48, 8'hA8, 8'h48};
        vecs[13] = '{8'h49, 8'hA8, 8'h4A};
        vecs[14] = '{8'h77, 8'hC8, 8'h77};
        vecs[15] = '{8'h77, 8'hD0, 8'h77};
        vecs[16] = '{8'h39, 8'h80, 8'h39};
        vecs[17] = '{8'h38, 8'h3C, 8'hB0};

        bus2.req0_valid = 1'b0; bus2.req0_a = 8'h40; bus2.req0_b = 8'h38;
        bus2.req1_valid = 1'b0; bus2.req1_a = 8'h00; bus2.req1_b = 8'h00;
        bus2.out_ready  = 1'b1;
        drive(1'b1, 8'h40, 8'h38, 1'b1, 8'h38, 8'h40, 1'b1);

        // Reset state, readies low while rst is high
        rst = 1'b1;
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_y",     32'(bus.out_y),     32'd0);
        chk("rst_out_id",    32'(bus.out_id),    32'd0);
        chk("rst_op_count",  32'(bus.op_count),  32'd0);
        chk("rst_ready0",    32'(bus.req0_ready), 32'd0);
        chk("rst_ready1",    32'(bus.req1_ready), 32'd0);
        tick();
        rst = 1'b0;

        // Single accept, latency one cycle
        drive(1'b1, 8'h40, 8'h38, 1'b0, 8'h00, 8'h00, 1'b1);
        #1;
        chk("single_ready0", 32'(bus.req0_ready), 32'd1);
        tick();
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        chk("single_y",     32'(bus.out_y),     32'h38);
        chk("single_id",    32'(bus.out_id),    32'd0);
        chk("single_cnt",   32'(bus.op_count),  32'd1);

        // Round-robin with both requesters valid every cycle
        pulse_reset();
        drive(1'b1, 8'h40, 8'h38, 1'b1, 8'h38, 8'h40, 1'b1);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready0", 32'(bus.req0_ready), 32'(k % 2 == 0));
            chk("rr_ready1", 32'(bus.req1_ready), 32'(k % 2 == 1));
            tick();
            chk("rr_valid", 32'(bus.out_valid), 32'd1);
            chk("rr_y",     32'(bus.out_y),     (k % 2 == 0) ? 32'h38 : 32'hB8);
            chk("rr_id",    32'(bus.out_id),    32'(k % 2));
            chk("rr_cnt",   32'(bus.op_count),  32'(k + 1));
        end

        // Backpressure holds the result and blocks both requesters
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready0", 32'(bus.req0_ready), 32'd0);
            chk("bp_ready1", 32'(bus.req1_ready), 32'd0);
            tick();
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_y",     32'(bus.out_y),     32'hB8);
            chk("bp_id",    32'(bus.out_id),    32'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready0", 32'(bus.req0_ready), 32'd1);
        tick();
        chk("bp_release_y",   32'(bus.out_y),    32'h38);
        chk("bp_release_id",  32'(bus.out_id),   32'd0);
        chk("bp_release_cnt", 32'(bus.op_count), 32'd5);

        // Operand vector table through requester 0
        pulse_reset();
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, 1'b0, 8'h00, 8'h00, 1'b1);
            tick();
            chk($sformatf("vec%0d_%0h_%0h", i, vecs[i].a, vecs[i].b), 32'(bus.out_y), 32'(vecs[i].y));
        end
        chk("vec_cnt", 32'(bus.op_count), 32'd18);

        // Asynchronous reset mid-cycle with a pending result; pointer returns to requester 0
        drive(1'b1, 8'h40, 8'h38, 1'b1, 8'h38, 8'h40, 1'b0);
        rst = 1'b1;
        #1;
        chk("arst_valid",  32'(bus.out_valid),  32'd0);
        chk("arst_cnt",    32'(bus.op_count),   32'd0);
        chk("arst_y",      32'(bus.out_y),      32'd0);
        chk("arst_ready0", 32'(bus.req0_ready), 32'd0);
        #2;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("arst_next_ready0", 32'(bus.req0_ready), 32'd1);
        chk("arst_next_ready1", 32'(bus.req1_ready), 32'd0);
        tick();
        chk("arst_next_id", 32'(bus.out_id), 32'd0);

        // Narrow counter wraps modulo 4
        pulse_reset();
        bus2.req0_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("wrap_cnt", 32'(bus2.op_count), 32'((k + 1) % 4));
        end
        bus2.req0_valid = 1'b0;

        // Randomized traffic against the reference model
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        pulse_reset();
        m_valid = 1'b0; m_id = 1'b0; m_ptr = 1'b0; m_y = 8'h00; m_cnt = 16'd0;
        hold0 = 1'b0; hold1 = 1'b0;
        v0 = 1'b0; v1 = 1'b0; a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
        for (int n = 0; n < 1500; n++) begin
            if (!hold0) begin
                v0 = ($urandom_range(0, 3) != 0);
                a0 = 8'($urandom);
                b0 = 8'($urandom);
            end
            if (!hold1) begin
                v1 = ($urandom_range(0, 3) != 0);
                a1 = 8'($urandom);
                b1 = 8'($urandom);
            end
            ordy = ($urandom_range(0, 9) < 7);
            drive(v0, a0, b0, v1, a1, b1, ordy);
            can = !m_valid || ordy;
            win = (v0 && v1) ? m_ptr : (v0 ? 1'b0 : 1'b1);
            e0  = can && v0 && (win == 1'b0);
            e1  = can && v1 && (win == 1'b1);
            #1;
            chk("rnd_ready0", 32'(bus.req0_ready), 32'(e0));
            chk("rnd_ready1", 32'(bus.req1_ready), 32'(e1));
            tick();
            if (e0 || e1) begin
                m_valid = 1'b1;
                m_id    = win;
                m_y     = win ? ref_sub(a1, b1) : ref_sub(a0, b0);
                m_ptr   = ~win;
                m_cnt   = m_cnt + 16'd1;
            end else if (ordy) begin
                m_valid = 1'b0;
            end
            hold0 = v0 && !e0;
            hold1 = v1 && !e1;
            chk("rnd_valid", 32'(bus.out_valid), 32'(m_valid));
            chk($sformatf("rnd_y_%0h_%0h", win ? a1 : a0, win ? b1 : b0), 32'(bus.out_y), 32'(m_y));
            chk("rnd_id",    32'(bus.out_id),    32'(m_id));
            chk("rnd_cnt",   32'(bus.op_count),  32'(m_cnt));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
